reaction_counter: RTL and testbench

Measures reaction time. It counts elapsed milliseconds from the moment the stimulus is asserted (the countdown-finished level) until the player's response button edge. It latches the result, flags false starts and timeouts, and keeps a best-time record for the display path. It is the measuring end of the trial: the countdown generates the random wait, and this block times the player.

---
 rtl/reaction_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/reaction_counter.sv | 119 +++++++++++
 tb/tb_reaction_counter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time trial: state encodings and the
// default time width shared with the countdown path.
package reaction_pkg;

  localparam int DEFAULT_WIDTH = 12;

  // All-ones doubles as the timeout value and the "no record yet" sentinel.
  localparam logic [DEFAULT_WIDTH-1:0] TIME_MAX = '1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_ARMED   = 3'd1;
  localparam state_t S_TIMING  = 3'd2;
  localparam state_t S_DONE    = 3'd3;
  localparam state_t S_EARLY   = 3'd4;
  localparam state_t S_TIMEOUT = 3'd5;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock down to a one-cycle tick every CLK_DIV cycles.
// Holding clear restarts the count, so the first tick is CLK_DIV cycles after release.
module tick_prescaler #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] count_reg;

  assign tick = (count_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/reaction_counter.sv
// Times the player from light-on to the response button edge in millisecond
// ticks, flags false starts and timeouts, and tracks the best valid time.
module reaction_counter
  import reaction_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stimulus,
  input  logic             response,
  output logic [WIDTH-1:0] reaction_time,
  output logic [WIDTH-1:0] best_time,
  output logic             valid,
  output logic             early,
  output logic             timeout,
  output logic             busy,
  output logic             light
);

  localparam logic [WIDTH-1:0] TIME_LIMIT = '1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] counter_reg, counter_next;
  logic [WIDTH-1:0] reaction_reg, reaction_next;
  logic [WIDTH-1:0] best_reg, best_next;
  logic             resp_meta_reg, resp_sync_reg, resp_prev_reg;
  logic             resp_edge;
  logic             tick;

  assign resp_edge = resp_sync_reg & ~resp_prev_reg;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (state_reg != S_TIMING),
    .tick  (tick)
  );

  always_comb begin
    state_next    = state_reg;
    counter_next  = counter_reg;
    reaction_next = reaction_reg;
    best_next     = best_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next   = S_ARMED;
          counter_next = '0;
        end
      end
      S_ARMED: begin
        // A press before the light counts as a false start even if the light comes on now.
        if (resp_edge) begin
          state_next = S_EARLY;
        end else if (stimulus) begin
          state_next   = S_TIMING;
          counter_next = '0;
        end
      end
      S_TIMING: begin
        if (resp_edge) begin
          state_next    = S_DONE;
          reaction_next = counter_reg;
          if (counter_reg < best_reg) begin
            best_next = counter_reg;
          end
        end else if (tick) begin
          if (counter_reg == TIME_LIMIT) begin
            state_next    = S_TIMEOUT;
            reaction_next = TIME_LIMIT;
          end else begin
            counter_next = counter_reg + 1'b1;
          end
        end
      end
      S_DONE, S_EARLY, S_TIMEOUT: begin
        if (start) begin
          state_next   = S_ARMED;
          counter_next = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      counter_reg   <= '0;
      reaction_reg  <= '0;
      best_reg      <= TIME_LIMIT;
      resp_meta_reg <= 1'b0;
      resp_sync_reg <= 1'b0;
      resp_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      counter_reg   <= counter_next;
      reaction_reg  <= reaction_next;
      best_reg      <= best_next;
      resp_meta_reg <= response;
      resp_sync_reg <= resp_meta_reg;
      resp_prev_reg <= resp_sync_reg;
    end
  end

  assign reaction_time = reaction_reg;
  assign best_time     = best_reg;
  assign valid         = (state_reg == S_DONE);
  assign early         = (state_reg == S_EARLY);
  assign timeout       = (state_reg == S_TIMEOUT);
  assign busy          = (state_reg == S_ARMED) || (state_reg == S_TIMING);
  assign light         = (state_reg == S_TIMING);

endmodule

// File: tb/tb_reaction_counter.sv
// Directed bench: main instance at CLK_DIV=4/WIDTH=12, a second at CLK_DIV=2/WIDTH=4 for timeout.
module tb_reaction_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stimulus = 1'b0, response = 1'b0;
  logic [11:0] reaction_time, best_time;
  logic        valid, early, timeout, busy, light;

  logic        start_t = 1'b0, stimulus_t = 1'b0, response_t = 1'b0;
  logic [3:0]  reaction_time_t, best_time_t;
  logic        valid_t, early_t, timeout_t, busy_t, light_t;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reaction_counter #(.CLK_DIV(4), .WIDTH(12)) dut (
    .clk(clk), .rst(rst), .start(start), .stimulus(stimulus), .response(response),
    .reaction_time(reaction_time), .best_time(best_time), .valid(valid),
    .early(early), .timeout(timeout), .busy(busy), .light(light)
  );

  reaction_counter #(.CLK_DIV(2), .WIDTH(4)) dut_t (
    .clk(clk), .rst(rst), .start(start_t), .stimulus(stimulus_t), .response(response_t),
    .reaction_time(reaction_time_t), .best_time(best_time_t), .valid(valid_t),
    .early(early_t), .timeout(timeout_t), .busy(busy_t), .light(light_t)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // From ARMED: light on, press after edge 4n+off (off 0 or 1) of TIMING, expect n ms.
  task automatic run_trial(input int n, input int off);
    stimulus = 1'b1;
    step(1);
    stimulus = 1'b0;
    step(4 * n + off);
    response = 1'b1;
    step(3);
    response = 1'b0;
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    step(1);

    check("reset_rt", reaction_time, 0);
    check("reset_best", best_time, 12'hFFF);
    check("reset_flags", {valid, early, timeout, busy, light}, 5'b0);

    // Normal trial: 37 ms, press on the edge that is also a tick.
    pulse_start();
    check("armed_busy", {busy, light}, 2'b10);
    step(9);
    run_trial(37, 1);
    check("t37_valid", valid, 1);
    check("t37_rt", reaction_time, 37);
    check("t37_best", best_time, 37);
    check("t37_light", {light, busy}, 2'b00);
    step(3);

    // False start.
    pulse_start();
    response = 1'b1;
    step(3);
    response = 1'b0;
    check("early_flag", early, 1);
    check("early_rt", reaction_time, 37);
    check("early_best", best_time, 37);
    step(3);
    pulse_start();
    check("rearm_busy_early", {busy, early}, 2'b10);

    run_trial(20, 0);
    check("t20_rt", reaction_time, 20);
    check("t20_best", best_time, 20);
    step(3);

    pulse_start();
    run_trial(25, 1);
    check("t25_rt", reaction_time, 25);
    check("t25_best", best_time, 20);
    step(3);

    pulse_start();
    response = 1'b1;
    step(3);
    response = 1'b0;
    check("early2_best", {early, best_time}, {1'b1, 12'd20});
    step(3);

    // Tie: resp_edge on the tick that would take the counter from 5 to 6.
    pulse_start();
    run_trial(5, 1);
    check("tie_rt", reaction_time, 5);
    check("tie_best", best_time, 5);
    step(3);

    // resp_edge and stimulus together in ARMED -> false start.
    pulse_start();
    response = 1'b1;
    step(2);
    stimulus = 1'b1;
    step(1);
    stimulus = 1'b0;
    response = 1'b0;
    check("armed_tie_early", {early, light}, 2'b10);
    step(3);

    // Timeout on the WIDTH=4, CLK_DIV=2 instance.
    start_t = 1'b1;
    step(1);
    start_t = 1'b0;
    stimulus_t = 1'b1;
    step(1);
    stimulus_t = 1'b0;
    step(31);
    check("to_before", {timeout_t, light_t}, 2'b01);
    step(1);
    check("to_flag", {timeout_t, light_t, busy_t}, 3'b100);
    check("to_rt", reaction_time_t, 15);
    check("to_best", best_time_t, 15);

    // Async reset mid-TIMING.
    pulse_start();
    stimulus = 1'b1;
    step(1);
    stimulus = 1'b0;
    step(10);
    check("pre_rst_light", light, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_drop", {light, busy}, 2'b00);
    step(1);
    rst = 1'b0;
    step(1);
    check("post_rst_best", best_time, 12'hFFF);
    check("post_rst_rt", reaction_time, 0);
    check("post_rst_idle", {valid, early, timeout, busy, light}, 5'b0);
    pulse_start();
    check("idle_to_armed", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
